// File: rtl/smc_stream_calc.sv
// Streaming MOSFET channel calculator: loads N_CH channel beats, sorts them, and averages three selected values.
// Optional build macro SMC_STREAM_CALC_ROUND_EN selects half-up rounding on the final division.
module smc_stream_calc #(
    parameter int unsigned N_CH = 6,
    parameter int unsigned VW   = 3,
    localparam int unsigned OW  = 3*VW+1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [1:0]    mode,
    input  logic [VW-1:0] w,
    input  logic [VW-1:0] v_gs,
    input  logic [VW-1:0] v_ds,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [OW-1:0] out_n
);

    localparam int unsigned CW = 3*VW;
    localparam int unsigned PW = 3*VW+2;
    localparam int unsigned SW = CW+4;
    localparam int unsigned IW = $clog2(N_CH);

    typedef enum logic [2:0] {IDLE, LOAD, SORT, SUM, OUT} state_t;

    state_t          state, state_next;
    logic [IW-1:0]   cnt;
    logic [1:0]      mode_q;
    logic [CW-1:0]   vals   [N_CH];
    logic [CW-1:0]   sorted [N_CH];
    logic [CW-1:0]   chan_val;
    logic [CW-1:0]   n0, n1, n2;
    logic [SW-1:0]   cur_sum, gm_sum;
    logic [OW-1:0]   result;
    logic            accept, last_beat, cur_sel;

    // Drain current (cur=1) or transconductance of one channel, floor-divided by 3.
    function automatic logic [CW-1:0] chan_value(input logic cur, input logic [VW-1:0] w_i,
                                                 input logic [VW-1:0] g_i, input logic [VW-1:0] d_i);
        logic [VW-1:0] ov;
        logic [PW-1:0] pw, pov, pd, prod;
        ov   = (g_i > VW'(1)) ? g_i - VW'(1) : '0;
        pw   = PW'(w_i);
        pov  = PW'(ov);
        pd   = PW'(d_i);
        if (ov == '0)
            prod = '0;
        else if (ov > d_i)
            prod = cur ? pw * (PW'(2) * pov * pd - pd * pd) : PW'(2) * pw * pd;
        else
            prod = cur ? pw * pov * pov : PW'(2) * pw * pov;
        return CW'(prod / PW'(3));
    endfunction

    assign accept    = in_valid && in_ready;
    assign last_beat = (cnt == IW'(N_CH-1));
    // Mode is taken live on beat 0 and from the latch for the rest of the frame.
    assign cur_sel   = (state == IDLE) ? mode[0] : mode_q[0];
    assign chan_val  = chan_value(cur_sel, w, v_gs, v_ds);

    // One odd-even transposition pass, descending; cnt parity picks the pair phase.
    always_comb begin
        sorted = vals;
        for (int i = 0; i < int'(N_CH) - 1; i++) begin
            if ((i[0] == cnt[0]) && (vals[IW'(i+1)] > vals[IW'(i)])) begin
                sorted[IW'(i)]   = vals[IW'(i+1)];
                sorted[IW'(i+1)] = vals[IW'(i)];
            end
        end
    end

    always_comb begin
        if (mode_q[1]) begin
            n0 = vals[IW'(0)];
            n1 = vals[IW'(1)];
            n2 = vals[IW'(2)];
        end else begin
            n0 = vals[IW'(N_CH-3)];
            n1 = vals[IW'(N_CH-2)];
            n2 = vals[IW'(N_CH-1)];
        end
        cur_sum = SW'(3) * SW'(n0) + SW'(4) * SW'(n1) + SW'(5) * SW'(n2);
        gm_sum  = SW'(n0) + SW'(n1) + SW'(n2);
`ifdef SMC_STREAM_CALC_ROUND_EN
        result  = mode_q[0] ? OW'((cur_sum + SW'(6)) / SW'(12)) : OW'((gm_sum + SW'(1)) / SW'(3));
`else
        result  = mode_q[0] ? OW'(cur_sum / SW'(12)) : OW'(gm_sum / SW'(3));
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept) state_next = last_beat ? SORT : LOAD;
            LOAD:    if (accept && last_beat) state_next = SORT;
            SORT:    if (last_beat) state_next = SUM;
            SUM:     state_next = OUT;
            OUT:     if (out_valid && out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Datapath registers; cnt doubles as beat index while loading and pass index while sorting.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt       <= '0;
            mode_q    <= '0;
            vals      <= '{default: '0};
            out_valid <= 1'b0;
            out_n     <= '0;
            in_ready  <= 1'b1;
        end else begin
            in_ready <= (state_next == IDLE) || (state_next == LOAD);
            case (state)
                IDLE, LOAD: begin
                    if (accept) begin
                        vals[cnt] <= chan_val;
                        if (state == IDLE) mode_q <= mode;
                        cnt <= last_beat ? '0 : cnt + IW'(1);
                    end
                end
                SORT: begin
                    vals <= sorted;
                    cnt  <= last_beat ? '0 : cnt + IW'(1);
                end
                SUM: begin
                    out_valid <= 1'b1;
                    out_n     <= result;
                end
                OUT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        out_n     <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_smc_stream_calc.sv
// Directed self-checking bench for smc_stream_calc with hand-computed expected results.
module tb_smc_stream_calc;

    localparam int N  = 6;
    localparam int VW = 3;
    localparam int OW = 3*VW+1;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [1:0]    mode;
    logic [VW-1:0] w, v_gs, v_ds;
    logic          out_valid;
    logic          out_ready;
    logic [OW-1:0] out_n;

    int total = 0;
    int bad   = 0;
    int w_t[N], g_t[N], d_t[N];
    int lat;

`ifdef SMC_STREAM_CALC_ROUND_EN
    localparam int EXP_028 = 2;
`else
    localparam int EXP_028 = 1;
`endif

    smc_stream_calc #(.N_CH(N), .VW(VW)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .mode(mode),
        .w(w), .v_gs(v_gs), .v_ds(v_ds), .out_valid(out_valid), .out_ready(out_ready), .out_n(out_n)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Drive nb beats from the tables; mode is only valid on beat 0, inverted afterwards.
    task automatic send_beats(input logic [1:0] m, input int nb);
        int tries;
        for (int i = 0; i < nb; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            mode     = (i == 0) ? m : ~m;
            w        = VW'(w_t[i]);
            v_gs     = VW'(g_t[i]);
            v_ds     = VW'(d_t[i]);
            tries = 0;
            while (!in_ready && tries < 20) begin
                @(negedge clk);
                tries++;
            end
            check("beat_ready", 32'(in_ready), 32'd1);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_result(input string tag, input int exp);
        lat = 0;
        while (!out_valid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        check({tag, "_latency"}, 32'(lat), 32'(N + 1));
        check({tag, "_out_n"}, 32'(out_n), 32'(exp));
    endtask

    task automatic take_result(input string tag);
        @(posedge clk); #1;
        check({tag, "_valid_drop"}, 32'(out_valid), 32'd0);
        check({tag, "_n_clear"}, 32'(out_n), 32'd0);
        check({tag, "_ready_back"}, 32'(in_ready), 32'd1);
    endtask

    task automatic run_frame(input string tag, input logic [1:0] m, input int exp);
        send_beats(m, N);
        check({tag, "_busy"}, 32'(in_ready), 32'd0);
        wait_result(tag, exp);
        take_result(tag);
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; mode = '0;
        w = '0; v_gs = '0; v_ds = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_n", 32'(out_n), 32'd0);
        @(negedge clk); rst = 1'b0;

        // gm, smallest three: values 2,2,1,2,2,2
        w_t = '{2, 2, 2, 2, 2, 2}; g_t = '{3, 3, 2, 3, 3, 3}; d_t = '{4, 4, 4, 4, 4, 4};
        run_frame("gm_small", 2'b00, EXP_028);

        // current, largest three: values 2,50,8,2,1,84
        w_t = '{2, 6, 1, 2, 1, 7}; g_t = '{3, 6, 6, 3, 3, 7}; d_t = '{7, 6, 7, 5, 5, 7};
        run_frame("cur_large", 2'b11, 41);

        // all channels in triode
        w_t = '{7, 7, 7, 7, 7, 7}; g_t = '{7, 7, 7, 7, 7, 7}; d_t = '{1, 1, 1, 1, 1, 1};
        run_frame("triode_cur", 2'b01, 25);
        run_frame("triode_gm", 2'b00, 4);

        // channels below threshold
        w_t = '{7, 7, 7, 7, 7, 7}; g_t = '{0, 1, 0, 1, 0, 1}; d_t = '{3, 3, 3, 3, 3, 3};
        run_frame("off_cur", 2'b11, 0);
        run_frame("off_gm", 2'b10, 0);

        // backpressure with stray beats offered while the result waits
        @(negedge clk); out_ready = 1'b0;
        w_t = '{2, 6, 1, 2, 1, 7}; g_t = '{3, 6, 6, 3, 3, 7}; d_t = '{7, 6, 7, 5, 5, 7};
        send_beats(2'b11, N);
        wait_result("bp", 41);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            in_valid = 1'b1; mode = 2'b01; w = 3'd7; v_gs = 3'd7; v_ds = 3'd7;
            @(posedge clk); #1;
            check("bp_hold_valid", 32'(out_valid), 32'd1);
            check("bp_hold_n", 32'(out_n), 32'd41);
            check("bp_in_ready", 32'(in_ready), 32'd0);
        end
        @(negedge clk); in_valid = 1'b0; out_ready = 1'b1;
        @(posedge clk); #1;
        check("bp_release_valid", 32'(out_valid), 32'd0);
        check("bp_release_n", 32'(out_n), 32'd0);
        check("bp_release_ready", 32'(in_ready), 32'd1);
        w_t = '{2, 2, 2, 2, 2, 2}; g_t = '{3, 3, 2, 3, 3, 3}; d_t = '{4, 4, 4, 4, 4, 4};
        run_frame("post_bp", 2'b00, EXP_028);

        // reset after four beats, then a clean frame
        w_t = '{7, 7, 7, 7, 7, 7}; g_t = '{7, 7, 7, 7, 7, 7}; d_t = '{7, 7, 7, 7, 7, 7};
        send_beats(2'b01, 4);
        @(negedge clk); rst = 1'b1;
        @(posedge clk); #1;
        check("midrst_in_ready", 32'(in_ready), 32'd1);
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_out_n", 32'(out_n), 32'd0);
        @(negedge clk); rst = 1'b0;
        w_t = '{2, 6, 1, 2, 1, 7}; g_t = '{3, 6, 6, 3, 3, 7}; d_t = '{7, 6, 7, 5, 5, 7};
        run_frame("after_rst", 2'b11, 41);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
